// File: rtl/jt12_op_sched.sv
// Operator slot sequencer: walks 4*num_ch slots (S1,S3,S2,S4 groups) and issues a registered
// control word per slot, with modulator selects decoded from the channel algorithm.
module jt12_op_sched #(
  parameter int num_ch = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  output logic [2:0] ch,
  input  logic [2:0] alg_in,
  input  logic [2:0] fb_in,
  output logic [4:0] slot,
  output logic       s1_enters,
  output logic       s2_enters,
  output logic       s3_enters,
  output logic       s4_enters,
  output logic       zero,
  output logic       xuse_prevprev1,
  output logic       xuse_prev2,
  output logic       xuse_internal,
  output logic       yuse_prev1,
  output logic       yuse_prev2,
  output logic       yuse_internal,
  output logic [2:0] fb_II
);

  localparam logic [2:0] LAST_CH   = 3'(num_ch - 1);
  localparam logic [4:0] LAST_SLOT = 5'(4 * num_ch - 1);

  // r_grp counts operator groups in issue order: 0=S1, 1=S3, 2=S2, 3=S4
  logic [4:0] r_cnt;
  logic [2:0] r_ch;
  logic [1:0] r_grp;
  logic [2:0] r_fb;

  logic w_x_pp1, w_x_p2, w_x_int;
  logic w_y_p1, w_y_p2, w_y_int;

  assign ch = r_ch;

  always_comb begin
    w_x_pp1 = 1'b0;
    w_x_p2  = 1'b0;
    w_x_int = 1'b0;
    w_y_p1  = 1'b0;
    w_y_p2  = 1'b0;
    w_y_int = 1'b0;
    case (r_grp)
      2'd0: begin
        w_x_pp1 = 1'b1;
        w_y_p1  = 1'b1;
      end
      2'd1: begin
        w_x_p2  = (alg_in <= 3'd2);
        w_y_p1  = (alg_in == 3'd1);
        w_x_pp1 = (alg_in == 3'd5);
      end
      2'd2: begin
        w_y_p1 = (alg_in == 3'd0) || (alg_in == 3'd3) || (alg_in == 3'd4) ||
                 (alg_in == 3'd5) || (alg_in == 3'd6);
      end
      default: begin
        w_y_int = (alg_in == 3'd0) || (alg_in == 3'd1) || (alg_in == 3'd4);
        w_x_int = (alg_in == 3'd2);
        w_x_p2  = (alg_in == 3'd3);
        w_y_p1  = (alg_in == 3'd5);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= 5'd0;
      r_ch           <= 3'd0;
      r_grp          <= 2'd0;
      r_fb           <= 3'd0;
      slot           <= 5'd0;
      s1_enters      <= 1'b0;
      s2_enters      <= 1'b0;
      s3_enters      <= 1'b0;
      s4_enters      <= 1'b0;
      zero           <= 1'b0;
      xuse_prevprev1 <= 1'b0;
      xuse_prev2     <= 1'b0;
      xuse_internal  <= 1'b0;
      yuse_prev1     <= 1'b0;
      yuse_prev2     <= 1'b0;
      yuse_internal  <= 1'b0;
      fb_II          <= 3'd0;
    end else if (clk_en) begin
      slot           <= r_cnt;
      s1_enters      <= (r_grp == 2'd0);
      s3_enters      <= (r_grp == 2'd1);
      s2_enters      <= (r_grp == 2'd2);
      s4_enters      <= (r_grp == 2'd3);
      zero           <= (r_cnt == 5'd0);
      xuse_prevprev1 <= w_x_pp1;
      xuse_prev2     <= w_x_p2;
      xuse_internal  <= w_x_int;
      yuse_prev1     <= w_y_p1;
      yuse_prev2     <= w_y_p2;
      yuse_internal  <= w_y_int;
      // fb is captured alongside the control word, then delayed once more for stage II
      r_fb           <= fb_in;
      fb_II          <= r_fb;
      r_cnt          <= (r_cnt == LAST_SLOT) ? 5'd0 : r_cnt + 5'd1;
      if (r_ch == LAST_CH) begin
        r_ch  <= 3'd0;
        r_grp <= r_grp + 2'd1;
      end else begin
        r_ch  <= r_ch + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_jt12_op_sched.sv
// Randomized bench for jt12_op_sched against a slot-level reference model.
module tb_jt12_op_sched;

  localparam int NCH   = 6;
  localparam int NSLOT = 4 * NCH;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [2:0] ch, alg_in, fb_in;
  logic [4:0] slot;
  logic       s1_enters, s2_enters, s3_enters, s4_enters, zero;
  logic       xuse_prevprev1, xuse_prev2, xuse_internal;
  logic       yuse_prev1, yuse_prev2, yuse_internal;
  logic [2:0] fb_II;

  logic [2:0] alg_tbl[NCH];
  logic [2:0] fb_tbl[NCH];

  assign alg_in = (ch < 3'(NCH)) ? alg_tbl[ch] : 3'd0;
  assign fb_in  = (ch < 3'(NCH)) ? fb_tbl[ch]  : 3'd0;

  jt12_op_sched #(.num_ch(NCH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ch(ch), .alg_in(alg_in), .fb_in(fb_in),
    .slot(slot), .s1_enters(s1_enters), .s2_enters(s2_enters), .s3_enters(s3_enters),
    .s4_enters(s4_enters), .zero(zero), .xuse_prevprev1(xuse_prevprev1),
    .xuse_prev2(xuse_prev2), .xuse_internal(xuse_internal), .yuse_prev1(yuse_prev1),
    .yuse_prev2(yuse_prev2), .yuse_internal(yuse_internal), .fb_II(fb_II)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state: m_cnt is the next slot to be issued
  int         m_cnt;
  logic [4:0] e_slot;
  logic [3:0] e_ent;   // {s4,s3,s2,s1}
  logic       e_zero;
  logic [2:0] e_x;     // {prevprev1, prev2, internal}
  logic [2:0] e_y;     // {prev1, prev2, internal}
  logic [2:0] e_fb, m_fb;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Operator fed by this slot and its modulator sources, straight from the algorithm table
  task automatic model_issue();
    int grp, chn, op;
    logic [2:0] a;
    grp = m_cnt / NCH;
    chn = m_cnt % NCH;
    a   = alg_tbl[chn];
    case (grp)
      0: op = 1;
      1: op = 3;
      2: op = 2;
      default: op = 4;
    endcase
    e_slot = 5'(m_cnt);
    e_ent  = 4'(1 << (op - 1));
    e_zero = (m_cnt == 0);
    e_x = 3'b000;
    e_y = 3'b000;
    if (op == 1) begin
      e_x = 3'b100;
      e_y = 3'b100;
    end else if (op == 3) begin
      if (a inside {3'd0, 3'd1, 3'd2}) e_x = 3'b010;
      if (a == 3'd5) e_x = 3'b100;
      if (a == 3'd1) e_y = 3'b100;
    end else if (op == 2) begin
      if (a inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd6}) e_y = 3'b100;
    end else begin
      if (a inside {3'd0, 3'd1, 3'd4}) e_y = 3'b001;
      if (a == 3'd2) e_x = 3'b001;
      if (a == 3'd3) e_x = 3'b010;
      if (a == 3'd5) e_y = 3'b100;
    end
    e_fb  = m_fb;
    m_fb  = fb_tbl[chn];
    m_cnt = (m_cnt + 1) % NSLOT;
  endtask

  task automatic check_all();
    chk("slot",   8'(slot), 8'(e_slot));
    chk("enters", 8'({s4_enters, s3_enters, s2_enters, s1_enters}), 8'(e_ent));
    chk("zero",   8'(zero), 8'(e_zero));
    chk("xsel",   8'({xuse_prevprev1, xuse_prev2, xuse_internal}), 8'(e_x));
    chk("ysel",   8'({yuse_prev1, yuse_prev2, yuse_internal}), 8'(e_y));
    chk("fb_II",  8'(fb_II), 8'(e_fb));
    chk("ch",     8'(ch), 8'(m_cnt % NCH));
  endtask

  task automatic step(input logic r, input logic en);
    @(negedge clk);
    rst    = r;
    clk_en = en;
    if (r) begin
      m_cnt = 0; e_slot = 0; e_ent = 0; e_zero = 0;
      e_x = 0; e_y = 0; e_fb = 0; m_fb = 0;
    end else if (en) begin
      model_issue();
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_tables(input logic [2:0] alg, input logic [2:0] fb);
    for (int i = 0; i < NCH; i++) begin
      alg_tbl[i] = alg;
      fb_tbl[i]  = fb;
    end
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b0;
    set_tables(3'd0, 3'd0);
    m_cnt = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // constant enable, alg 0, fb 5 only on channel 2
    fb_tbl[2] = 3'd5;
    for (int i = 0; i < 52; i++) step(1'b0, 1'b1);

    // alg 7 everywhere: only S1 slots carry selects
    set_tables(3'd7, 3'd0);
    for (int i = 0; i < 26; i++) step(1'b0, 1'b1);

    // alg 2 on channel 4 only
    set_tables(3'd0, 3'd0);
    alg_tbl[4] = 3'd2;
    for (int i = 0; i < 26; i++) begin
      step(1'b0, 1'b1);
      if (slot == 5'd10) chk("s3_alg2", 8'({xuse_prevprev1, xuse_prev2, xuse_internal,
                                           yuse_prev1, yuse_prev2, yuse_internal}), 8'b010000);
      if (slot == 5'd22) chk("s4_alg2", 8'({xuse_prevprev1, xuse_prev2, xuse_internal,
                                           yuse_prev1, yuse_prev2, yuse_internal}), 8'b001000);
    end

    // reset while slot 13 is on the outputs
    for (int i = 0; i < 2 * NSLOT && slot != 5'd13; i++) step(1'b0, 1'b1);
    chk("at_slot13", 8'(slot), 8'd13);
    step(1'b1, 1'b1);
    chk("rst_clear", 8'({s4_enters, s3_enters, s2_enters, s1_enters, zero}), 8'd0);
    step(1'b0, 1'b1);
    chk("restart_slot", 8'(slot), 8'd0);
    chk("restart_zero", 8'(zero), 8'd1);

    // random enable, occasional table edits and rare resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int c;
        c = $urandom_range(0, NCH - 1);
        alg_tbl[c] = 3'($urandom_range(0, 7));
        fb_tbl[c]  = 3'($urandom_range(0, 7));
      end
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
